// File: rtl/dram_sequencer.sv
// dram_sequencer
//   Turns the 16-phase slot count T and the slot owner Z_Source coming from
//   cpu_timing into DRAM strobes. Each T=0..15 slot is one of four kinds:
//   a CPU access, a video access, a RAS-only refresh, or an idle slot.
//   The slot kind is decided on the clock edge where T==0.
//
//   Build option: define DRAM_REFRESH_EN to include the refresh divider, the
//   pending-refresh (debt) counter and the refresh row counter. Without it,
//   every Z_Source=0 slot is a video slot and ref_busy stays 0
//   (SRAM-backed builds).
//
// Ports
//   clk, reset_n        master clock, asynchronous active-low reset
//   T                   slot phase 0..15
//   Z_Source            slot owner: 1 = CPU, 0 = video
//   isRAM, RnW          CPU address decodes to DRAM / CPU read(1) write(0)
//   cpu_addr, vdg_addr  CPU address / video address counter
//   mem_size            00 = 4K, 01 = 16K, 1x = 64K
//   RAS0_n, RAS1_n      row strobes for banks 0 and 1
//   CAS_n, WE_n         column strobe, write enable
//   Z                   multiplexed row/column address
//   ref_busy            current slot is a refresh slot
//   slot_dbg            current slot kind (0 idle, 1 cpu, 2 video, 3 refresh)
module dram_sequencer #(
    parameter int RAS_T    = 2,
    parameter int COL_T    = 4,
    parameter int CAS_T    = 6,
    parameter int END_T    = 12,
    parameter int REF_DIV  = 15,
    parameter int DEBT_MAX = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  T,
    input  logic        Z_Source,
    input  logic        isRAM,
    input  logic        RnW,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] vdg_addr,
    input  logic [1:0]  mem_size,
    output logic        RAS0_n,
    output logic        RAS1_n,
    output logic        CAS_n,
    output logic        WE_n,
    output logic [7:0]  Z,
    output logic        ref_busy,
    output logic [1:0]  slot_dbg
);

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_CPU     = 2'd1,
        SLOT_VIDEO   = 2'd2,
        SLOT_REFRESH = 2'd3
    } slot_e;

    localparam logic [3:0] RAS_P = 4'(RAS_T);
    localparam logic [3:0] COL_P = 4'(COL_T);
    localparam logic [3:0] CAS_P = 4'(CAS_T);
    localparam logic [3:0] END_P = 4'(END_T);

    slot_e       slot;
    slot_e       next_slot;
    logic [15:0] addr_q;
    logic        rnw_q;
    logic        bank_q;
    logic [15:0] in_addr;
    logic [6:0]  ref_row;
    logic        debt_pending;

    assign slot_dbg = slot;
    assign in_addr  = Z_Source ? cpu_addr : vdg_addr;

    function automatic logic [7:0] row_of(input logic [15:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   row_of = {2'b00, a[5:0]};
            2'b01:   row_of = {1'b0, a[6:0]};
            default: row_of = a[7:0];
        endcase
    endfunction

    function automatic logic [7:0] col_of(input logic [15:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   col_of = {2'b00, a[11:6]};
            2'b01:   col_of = {1'b0, a[13:7]};
            default: col_of = a[15:8];
        endcase
    endfunction

    function automatic logic bank_of(input logic [15:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   bank_of = a[12];
            2'b01:   bank_of = a[14];
            default: bank_of = 1'b0;
        endcase
    endfunction

    // Slot decision, evaluated against the registered debt so a debt
    // increment on this same T==0 edge only takes effect next slot.
    always_comb begin
        next_slot = SLOT_IDLE;
        if (!Z_Source && debt_pending) next_slot = SLOT_REFRESH;
        else if (!Z_Source)            next_slot = SLOT_VIDEO;
        else if (isRAM)                next_slot = SLOT_CPU;
    end

`ifdef DRAM_REFRESH_EN
    localparam int DIV_W  = (REF_DIV > 0) ? $clog2(REF_DIV + 1) : 1;
    localparam int DEBT_W = (DEBT_MAX > 0) ? $clog2(DEBT_MAX + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_TOP  = DIV_W'(REF_DIV);
    localparam logic [DEBT_W-1:0] DEBT_TOP = DEBT_W'(DEBT_MAX);

    logic [DIV_W-1:0]  div;
    logic [DEBT_W-1:0] debt;
    logic              ref_inc;
    logic              ref_done;

    assign debt_pending = (debt != '0);
    assign ref_inc      = (T == 4'd0) && (div == DIV_TOP);
    // Only a refresh slot that actually reaches END_T retires a debt; an
    // aborted one (T back to 0 early) never gets here.
    assign ref_done     = (T == END_P) && (slot == SLOT_REFRESH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            debt    <= '0;
            ref_row <= '0;
        end else begin
            if (T == 4'd0) begin
                if (div == DIV_TOP) div <= '0;
                else                div <= div + 1'b1;
            end
            if (ref_done) ref_row <= ref_row + 1'b1;
            case ({ref_inc, ref_done})
                2'b10: if (debt != DEBT_TOP) debt <= debt + 1'b1;
                2'b01: if (debt != '0)       debt <= debt - 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign debt_pending = 1'b0;
    assign ref_row      = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot     <= SLOT_IDLE;
            addr_q   <= '0;
            rnw_q    <= 1'b1;
            bank_q   <= 1'b0;
            RAS0_n   <= 1'b1;
            RAS1_n   <= 1'b1;
            CAS_n    <= 1'b1;
            WE_n     <= 1'b1;
            Z        <= '0;
            ref_busy <= 1'b0;
        end else if (T == 4'd0) begin
            // New slot. Strobes rise here too, which ends any slot that was
            // cut short by T returning to 0 before END_T.
            slot     <= next_slot;
            addr_q   <= in_addr;
            rnw_q    <= RnW;
            bank_q   <= bank_of(in_addr, mem_size);
            RAS0_n   <= 1'b1;
            RAS1_n   <= 1'b1;
            CAS_n    <= 1'b1;
            WE_n     <= 1'b1;
            ref_busy <= (next_slot == SLOT_REFRESH);
            case (next_slot)
                SLOT_REFRESH:         Z <= {1'b0, ref_row};
                SLOT_CPU, SLOT_VIDEO: Z <= row_of(in_addr, mem_size);
                default:              ;  // idle slot: Z holds
            endcase
        end else if (T == END_P) begin
            RAS0_n   <= 1'b1;
            RAS1_n   <= 1'b1;
            CAS_n    <= 1'b1;
            WE_n     <= 1'b1;
            ref_busy <= 1'b0;
            slot     <= SLOT_IDLE;
        end else if (T == RAS_P) begin
            if (slot == SLOT_REFRESH) begin
                RAS0_n <= 1'b0;
                RAS1_n <= 1'b0;
            end else if (slot == SLOT_CPU || slot == SLOT_VIDEO) begin
                if (bank_q) RAS1_n <= 1'b0;
                else        RAS0_n <= 1'b0;
            end
        end else if (T == COL_P) begin
            if (slot == SLOT_CPU || slot == SLOT_VIDEO) Z <= col_of(addr_q, mem_size);
        end else if (T == CAS_P) begin
            if (slot == SLOT_CPU || slot == SLOT_VIDEO) CAS_n <= 1'b0;
            if (slot == SLOT_CPU && !rnw_q)             WE_n  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dram_sequencer.sv
// tb_dram_sequencer
//   Directed bench for dram_sequencer. Inputs are driven 1 time unit after
//   each rising edge and outputs are sampled at the same point, so a value
//   captured after the edge where T==k shows the effect of T==k.
//   Refresh scenarios run only when DRAM_REFRESH_EN is defined; otherwise
//   the bench checks that video-owned slots never become refresh slots.
module tb_dram_sequencer;

    logic        clk;
    logic        reset_n;
    logic [3:0]  T;
    logic        Z_Source;
    logic        isRAM;
    logic        RnW;
    logic [15:0] cpu_addr;
    logic [15:0] vdg_addr;
    logic [1:0]  mem_size;
    logic        RAS0_n;
    logic        RAS1_n;
    logic        CAS_n;
    logic        WE_n;
    logic [7:0]  Z;
    logic        ref_busy;
    logic [1:0]  slot_dbg;

    int total;
    int bad;

    logic [7:0] exp_q[$];

    logic       o_ras0 [0:15];
    logic       o_ras1 [0:15];
    logic       o_cas  [0:15];
    logic       o_we   [0:15];
    logic [7:0] o_z    [0:15];
    logic       o_rb   [0:15];
    logic [1:0] o_slot [0:15];

    dram_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .T        (T),
        .Z_Source (Z_Source),
        .isRAM    (isRAM),
        .RnW      (RnW),
        .cpu_addr (cpu_addr),
        .vdg_addr (vdg_addr),
        .mem_size (mem_size),
        .RAS0_n   (RAS0_n),
        .RAS1_n   (RAS1_n),
        .CAS_n    (CAS_n),
        .WE_n     (WE_n),
        .Z        (Z),
        .ref_busy (ref_busy),
        .slot_dbg (slot_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        T       = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // checking
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic tick(input logic [3:0] t);
        T = t;
        @(posedge clk); #1;
    endtask

    task automatic run_slot(input int first_t, input int last_t);
        for (int t = first_t; t <= last_t; t++) begin
            tick(4'(t));
            o_ras0[t] = RAS0_n;
            o_ras1[t] = RAS1_n;
            o_cas[t]  = CAS_n;
            o_we[t]   = WE_n;
            o_z[t]    = Z;
            o_rb[t]   = ref_busy;
            o_slot[t] = slot_dbg;
        end
    endtask

    task automatic quick_edges(input int n);
        for (int i = 0; i < n; i++) tick(4'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        Z_Source = 1'b1;
        isRAM    = 1'b0;
        RnW      = 1'b1;
        cpu_addr = '0;
        vdg_addr = '0;
        mem_size = 2'b10;
        do_reset();

        // reset state
        chk("rst_strobes", {RAS0_n, RAS1_n, CAS_n, WE_n}, 4'hF);
        chk("rst_z", Z, 8'h00);
        chk("rst_ref_busy", ref_busy, 1'b0);
        chk("rst_slot", slot_dbg, 2'd0);

        // 64K CPU read of 0x1234
        mem_size = 2'b10; Z_Source = 1'b1; isRAM = 1'b1; RnW = 1'b1; cpu_addr = 16'h1234;
        run_slot(0, 15);
        chk("rd64_slot", o_slot[0], 2'd1);
        chk("rd64_z_row", o_z[0], 8'h34);
        chk("rd64_ras0_t1", o_ras0[1], 1'b1);
        chk("rd64_ras0_t2", o_ras0[2], 1'b0);
        chk("rd64_ras1_t2", o_ras1[2], 1'b1);
        chk("rd64_z_t3", o_z[3], 8'h34);
        chk("rd64_z_col", o_z[4], 8'h12);
        chk("rd64_cas_t5", o_cas[5], 1'b1);
        chk("rd64_cas_t6", o_cas[6], 1'b0);
        chk("rd64_we_t6", o_we[6], 1'b1);
        chk("rd64_hold_t11", {o_ras0[11], o_cas[11]}, 2'b00);
        chk("rd64_end_t12", {o_ras0[12], o_ras1[12], o_cas[12], o_we[12]}, 4'hF);

        // 16K CPU write of 0x5A81: bank 1, row 0x01, col 0x35
        mem_size = 2'b01; RnW = 1'b0; cpu_addr = 16'h5A81;
        run_slot(0, 15);
        chk("wr16_z_row", o_z[0], 8'h01);
        chk("wr16_z_col", o_z[4], 8'h35);
        chk("wr16_ras1_t2", o_ras1[2], 1'b0);
        chk("wr16_ras0_t2", o_ras0[2], 1'b1);
        chk("wr16_ras0_t11", o_ras0[11], 1'b1);
        chk("wr16_we_t5", o_we[5], 1'b1);
        chk("wr16_we_t6", o_we[6], 1'b0);
        chk("wr16_we_t11", o_we[11], 1'b0);
        chk("wr16_we_t12", o_we[12], 1'b1);
        chk("wr16_ras1_t12", o_ras1[12], 1'b1);

        // CPU slot that does not decode to DRAM: nothing moves, Z holds 0x35
        isRAM = 1'b0; RnW = 1'b1; cpu_addr = 16'hFFFF; mem_size = 2'b10;
        run_slot(0, 15);
        chk("idle_slot", o_slot[0], 2'd0);
        for (int t = 0; t < 16; t++) begin
            chk("idle_strobes", {o_ras0[t], o_ras1[t], o_cas[t], o_we[t]}, 4'hF);
            chk("idle_z_hold", o_z[t], 8'h35);
        end

        // 64K video slot at 0xBEEF
        Z_Source = 1'b0; vdg_addr = 16'hBEEF;
        run_slot(0, 15);
        chk("vid_slot", o_slot[0], 2'd2);
        chk("vid_ref_busy", o_rb[0], 1'b0);
        chk("vid_z_row", o_z[0], 8'hEF);
        chk("vid_z_col", o_z[4], 8'hBE);
        chk("vid_ras0_t2", o_ras0[2], 1'b0);
        chk("vid_cas_t6", o_cas[6], 1'b0);
        chk("vid_we_t6", o_we[6], 1'b1);

        // 4K CPU read of 0x1FC5: bank 1, row 0x05, col 0x3F
        Z_Source = 1'b1; isRAM = 1'b1; RnW = 1'b1; mem_size = 2'b00; cpu_addr = 16'h1FC5;
        run_slot(0, 15);
        chk("rd4_z_row", o_z[0], 8'h05);
        chk("rd4_z_col", o_z[4], 8'h3F);
        chk("rd4_ras1_t2", o_ras1[2], 1'b0);
        chk("rd4_ras0_t2", o_ras0[2], 1'b1);

        // CPU write aborted at T=8, followed by a video slot on the same edge
        mem_size = 2'b10; RnW = 1'b0; cpu_addr = 16'h1234;
        run_slot(0, 8);
        chk("abort_pre", {o_ras0[8], o_cas[8], o_we[8]}, 3'b000);
        Z_Source = 1'b0; vdg_addr = 16'h00AB;
        tick(4'd0);
        chk("abort_strobes", {RAS0_n, RAS1_n, CAS_n, WE_n}, 4'hF);
        chk("abort_z_row", Z, 8'hAB);
        chk("abort_slot", slot_dbg, 2'd2);
        run_slot(1, 15);
        chk("abort_next_ras", o_ras0[2], 1'b0);
        chk("abort_next_col", o_z[4], 8'h00);
        chk("abort_next_cas", o_cas[6], 1'b0);

        // asynchronous reset mid-slot
        Z_Source = 1'b1; isRAM = 1'b1; RnW = 1'b0; cpu_addr = 16'h1234;
        run_slot(0, 6);
        chk("mid_pre", {o_ras0[6], o_cas[6], o_we[6]}, 3'b000);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {RAS0_n, RAS1_n, CAS_n, WE_n}, 4'hF);
        chk("mid_rst_z", Z, 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_slot(7, 11);
        chk("mid_no_restart", {o_ras0[7], o_cas[7], o_we[7]}, 3'b111);
        run_slot(0, 15);
        chk("mid_restart_ras", o_ras0[2], 1'b0);
        chk("mid_restart_we", o_we[6], 1'b0);

`ifdef DRAM_REFRESH_EN
        // video-only traffic: a refresh slot every 16 slots, rows 0,1,2... wrap
        do_reset();
        Z_Source = 1'b0; mem_size = 2'b10; vdg_addr = 16'h4321;
        for (int n = 0; n < 130; n++) begin
            quick_edges((n == 0) ? 16 : 15);
            chk("ref_gap_video", slot_dbg, 2'd2);
            exp_q.push_back(8'(n % 128));
            run_slot(0, 15);
            chk("ref_slot", o_slot[0], 2'd3);
            chk("ref_busy_t0", o_rb[0], 1'b1);
            chk("ref_row", o_z[0], exp_q.pop_front());
            if (n == 0) begin
                chk("ref_ras_t2", {o_ras0[2], o_ras1[2]}, 2'b00);
                chk("ref_cas_t6", o_cas[6], 1'b1);
                chk("ref_we_t6", o_we[6], 1'b1);
                chk("ref_z_t4", o_z[4], 8'h00);
                chk("ref_end_t12", {o_ras0[12], o_ras1[12], o_rb[12]}, 3'b110);
            end
        end

        // 64 CPU-only slots: debt saturates at 3
        do_reset();
        Z_Source = 1'b1; isRAM = 1'b1; RnW = 1'b1; cpu_addr = 16'h0000;
        quick_edges(64);
        Z_Source = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_slot(0, 15);
            chk("debt_ref_slot", o_slot[0], 2'd3);
            chk("debt_ref_row", o_z[0], 8'(k));
        end
        run_slot(0, 15);
        chk("debt_video_back", o_slot[0], 2'd2);
        chk("debt_video_rb", o_rb[0], 1'b0);
        chk("debt_video_row", o_z[0], 8'h21);

        // refresh aborted at T=8: row and debt unchanged
        do_reset();
        Z_Source = 1'b0;
        quick_edges(16);
        run_slot(0, 8);
        chk("refab_pre", {o_rb[8], o_ras0[8], o_ras1[8]}, 3'b100);
        tick(4'd0);
        chk("refab_strobes", {RAS0_n, RAS1_n, CAS_n, WE_n}, 4'hF);
        chk("refab_again", slot_dbg, 2'd3);
        chk("refab_row", Z, 8'h00);
        run_slot(1, 15);
        chk("refab_done", o_rb[12], 1'b0);
        tick(4'd0);
        chk("refab_debt_clear", slot_dbg, 2'd2);
        tick(4'd0);
        chk("refab_row_adv", {ref_busy, slot_dbg}, 3'b010);
`else
        // without refresh logic every video-owned slot stays a video slot
        Z_Source = 1'b0; vdg_addr = 16'h4321;
        for (int i = 0; i < 40; i++) begin
            tick(4'd0);
            chk("noref_slot", {ref_busy, slot_dbg}, 3'b010);
        end
        run_slot(0, 15);
        chk("noref_cas", o_cas[6], 1'b0);
        chk("noref_rb", o_rb[6], 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
